pattern_seq_gen: RTL and testbench
==================================

# pattern_seq_gen

Parametrised serial pattern generator: a trigger on `I` launches a programmable LEN-bit pattern on `O`, LSB first, one bit per enabled clock. This is the next generation of the fixed 3-flop sequence generator. It adds runtime pattern loading, a clock enable, a configurable retrigger mode and a guard gap between patterns. It sits between control logic that raises triggers and the serial line or stimulus path that consumes `O`.

## Interface
- `LEN`, 8: pattern length in bits; legal range 1..32.
- `PATTERN`, 8'hB1: reset value of the pattern register, LEN bits wide, emitted LSB first.
- `GAP`, 0: idle guard cycles after a pattern before a new trigger is accepted; legal range 0..255.
- `RETRIG`, 0: 0 = triggers during emission are ignored; 1 = a trigger during emission restarts the pattern.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low: 0 resets immediately, independent of `clk`.
- `en`  in  1  clock enable; when 0, the state machine, counters and shifter freeze.
- `I`  in  1  trigger, sampled on the rising edge when `en`=1.
- `load`  in  1  when 1, `pat_in` is written to the pattern register on the rising edge; independent of `en`.
- `pat_in`  in  LEN  new pattern value.
- `O`  out  1  serial pattern output.
- `busy`  out  1  high in EMIT and GAP.
- `last`  out  1  high during the cycle in which the final pattern bit is on `O`.

## Operation
- Registers:
  - `pat_q` (LEN bits): pattern register.
  - `sr` (LEN bits): shift register.
  - `cnt`: bit counter, $clog2(LEN+1) bits.
  - `gcnt`: gap counter, 8 bits.
  - `state`: IDLE, EMIT or GAP.
- Reset (`reset`=0): `state`=IDLE, `pat_q`=PATTERN, `sr`=0, `cnt`=0, `gcnt`=0. All outputs are 0 immediately.
- Output decode:
  - `O` = `sr[0]` in EMIT, else 0.
  - `busy` = (state != IDLE).
  - `last` = (state==EMIT && cnt==0).
- IDLE, `en`=1 and `I`=1: `sr`<=`pat_q`, `cnt`<=LEN-1, go to EMIT.
- EMIT, `en`=1, `cnt`!=0:
  - `sr`<=`sr`>>1 and `cnt`<=`cnt`-1.
  - If RETRIG=1 and `I`=1, instead reload: `sr`<=`pat_q`, `cnt`<=LEN-1.
- EMIT, `en`=1, `cnt`==0 (last bit):
  - Restart (`sr`<=`pat_q`, `cnt`<=LEN-1, stay in EMIT) if `I`=1 and either RETRIG=1 or GAP=0.
  - Otherwise, if GAP>0, go to GAP with `gcnt`<=GAP-1.
  - Otherwise go to IDLE.
- GAP, `en`=1:
  - `I` is ignored.
  - If `gcnt`==0, go to IDLE; else `gcnt`<=`gcnt`-1.
- `en`=0: all of `state`, `sr`, `cnt` and `gcnt` hold, and `I` is ignored. Outputs hold their decoded values.
- `load` writes `pat_q` in any state. An emission in progress uses the captured `sr`, so the new value applies from the next trigger or restart.
- `load` and a start on the same edge: `sr` captures the old `pat_q`.
- LEN=1: EMIT lasts exactly one enabled cycle, with `last`=1 throughout.

## Timing
- Latency: trigger sampled at edge k puts bit 0 on `O` in cycle k+1 (between edges k and k+1). Bit i appears in cycle k+1+i, assuming `en`=1 throughout.
- `last` is high in cycle k+LEN.
- `busy` is high in cycles k+1 .. k+LEN+GAP. It falls after the edge that ends the gap.
- With `en`=0 cycles inserted, each bit and each gap count stretches by the number of disabled cycles.
- Back-to-back patterns with no idle bit are possible only with GAP=0 and `I`=1 on the `last` cycle, or with RETRIG=1.
- Reset mid-emission: `O`, `busy` and `last` drop to 0 without a clock edge, and any loaded pattern is lost.
- After `reset` rises, the first trigger is accepted on the first rising edge.
- `O`, `busy` and `last` are decoded only from registers; there is no combinational path from `I`.

## Test plan
- Defaults, reset released, `I`=1 for one cycle at edge k -> `O` in cycles k+1..k+8 = 1,0,0,0,1,1,0,1. `last`=1 only in cycle k+8. `busy`=1 in k+1..k+8, then 0.
- `load`=1 with `pat_in`=8'h0F during emission -> current pattern unchanged. Next trigger emits 1,1,1,1,0,0,0,0.
- GAP=3, RETRIG=0, `I` held high -> 8 pattern bits, then 3 cycles with `O`=0 and `busy`=1. Next pattern bit 0 appears in the 5th cycle after `last` (1 IDLE cycle).
- RETRIG=1, second trigger at bit 3 -> `O` = 1,0,0,0 then restarts 1,0,0,0,1,1,0,1. `last` appears only once, at the end of the restarted pattern.
- `en` toggled 1,0,1,0 during emission -> each bit is held for 2 cycles, and the bit order is intact.
- `reset`=0 asserted asynchronously at bit 5 -> `O`, `busy` and `last` are 0 before the next edge. `pat_q` returns to 8'hB1, and the next trigger emits the default pattern.

Source files
------------

// File: rtl/pattern_seq_gen.sv
// Triggered serial pattern generator: shifts a programmable LEN-bit pattern out LSB first,
// with clock enable, optional retrigger and an idle guard gap between patterns.
module pattern_seq_gen #(
  parameter int               LEN     = 8,
  parameter logic [LEN-1:0]   PATTERN = 8'hB1,
  parameter int               GAP     = 0,
  parameter bit               RETRIG  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           I,
  input  logic           load,
  input  logic [LEN-1:0] pat_in,
  output logic           O,
  output logic           busy,
  output logic           last
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(LEN - 1);
  localparam logic [7:0]    GAP_TOP = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]     state;
  logic [LEN-1:0] pat_q;
  logic [LEN-1:0] sr;
  logic [CW-1:0]  cnt;
  logic [7:0]     gcnt;

  // Pattern loads ignore en so software can reprogram while the line is frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= PATTERN;
    end else if (load) begin
      pat_q <= pat_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (I) begin
            sr    <= pat_q;
            cnt   <= CNT_TOP;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (cnt != '0) begin
            if (RETRIG && I) begin
              sr  <= pat_q;
              cnt <= CNT_TOP;
            end else begin
              sr  <= sr >> 1;
              cnt <= cnt - 1'b1;
            end
          end else if (I && (RETRIG || (GAP == 0))) begin
            // Seamless back-to-back pattern: reload on the final bit.
            sr  <= pat_q;
            cnt <= CNT_TOP;
          end else if (GAP > 0) begin
            gcnt  <= GAP_TOP;
            state <= S_GAP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gcnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign O    = (state == S_EMIT) && sr[0];
  assign busy = (state != S_IDLE);
  assign last = (state == S_EMIT) && (cnt == '0);

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Directed bench for pattern_seq_gen: four instances (default, GAP=3, RETRIG=1, LEN=1)
// share stimulus; each scenario resets and checks the instance it targets.
module tb_pattern_seq_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       trig;
  logic       load;
  logic [7:0] patIn;

  logic oDef, busyDef, lastDef;
  logic oGap, busyGap, lastGap;
  logic oRet, busyRet, lastRet;
  logic oLen1, busyLen1, lastLen1;

  int checks = 0;
  int errors = 0;

  logic [7:0] patB1 = 8'hB1;
  logic [7:0] pat0F = 8'h0F;
  logic [7:0] patFF = 8'hFF;

  pattern_seq_gen uDef (
    .clk(clk), .reset(reset), .en(en), .I(trig), .load(load), .pat_in(patIn),
    .O(oDef), .busy(busyDef), .last(lastDef)
  );

  pattern_seq_gen #(.GAP(3)) uGap (
    .clk(clk), .reset(reset), .en(en), .I(trig), .load(load), .pat_in(patIn),
    .O(oGap), .busy(busyGap), .last(lastGap)
  );

  pattern_seq_gen #(.RETRIG(1'b1)) uRet (
    .clk(clk), .reset(reset), .en(en), .I(trig), .load(load), .pat_in(patIn),
    .O(oRet), .busy(busyRet), .last(lastRet)
  );

  pattern_seq_gen #(.LEN(1), .PATTERN(1'b1)) uLen1 (
    .clk(clk), .reset(reset), .en(en), .I(trig), .load(load), .pat_in(patIn[0:0]),
    .O(oLen1), .busy(busyLen1), .last(lastLen1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed outputs packed as {O, busy, last} for the selected instance.
  function automatic logic [2:0] obsOf(input int which);
    case (which)
      0:       return {oDef, busyDef, lastDef};
      1:       return {oGap, busyGap, lastGap};
      2:       return {oRet, busyRet, lastRet};
      default: return {oLen1, busyLen1, lastLen1};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed {O,busy,last}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input logic iv, input logic enV, input logic loadV,
                               input logic [7:0] patV);
    trig  = iv;
    en    = enV;
    load  = loadV;
    patIn = patV;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input string tag);
    reset = 1'b0;
    trig  = 1'b0;
    en    = 1'b1;
    load  = 1'b0;
    patIn = 8'h00;
    #1;
    checkOutput(tag, obsOf(0), 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Bit firstBit is expected on O now; later bits follow one per enabled step.
  task automatic expectPattern(input string tag, input int which, input logic [7:0] pat,
                               input int firstBit, input logic holdI);
    for (int i = firstBit; i < 8; i++) begin
      if (i != firstBit) applyStimulus(holdI, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("%s_bit%0d", tag, i), obsOf(which), {pat[i], 1'b1, (i == 7)});
    end
  endtask

  initial begin
    reset = 1'b1;
    trig  = 1'b0;
    en    = 1'b1;
    load  = 1'b0;
    patIn = 8'h00;
    #1;
    reset = 1'b0;
    #1;
    for (int w = 0; w < 4; w++) checkOutput($sformatf("init_reset_%0d", w), obsOf(w), 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Default pattern, single trigger.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    expectPattern("dflt", 0, patB1, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("dflt_idle", obsOf(0), 3'b000);

    // Load during emission affects only the next trigger.
    resetDut("rst_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("load_bit0", obsOf(0), 3'b110);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F);
    expectPattern("load_old", 0, patB1, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("load_idle", obsOf(0), 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    expectPattern("load_new", 0, pat0F, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("load_new_idle", obsOf(0), 3'b000);

    // GAP=3 with trigger held high.
    resetDut("rst_gap");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    expectPattern("gap", 1, patB1, 0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("gap_cycle%0d", g), obsOf(1), 3'b010);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("gap_idle", obsOf(1), 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("gap_next_bit0", obsOf(1), 3'b110);

    // RETRIG=1: second trigger while bit 3 is on the line.
    resetDut("rst_ret");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("ret1_bit%0d", i), obsOf(2), {patB1[i], 2'b10});
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    expectPattern("ret2", 2, patB1, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("ret_idle", obsOf(2), 3'b000);

    // Enable toggling stretches every bit to two cycles.
    resetDut("rst_en");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("en_on_bit%0d", i), obsOf(0), {patB1[i], 1'b1, (i == 7)});
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("en_off_bit%0d", i), obsOf(0), {patB1[i], 1'b1, (i == 7)});
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checkOutput("en_idle", obsOf(0), 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("en_off_trig_ignored", obsOf(0), 3'b000);

    // Asynchronous reset mid-emission discards a loaded pattern.
    resetDut("rst_async");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("async_ff_bit%0d", i), obsOf(0), {patFF[i], 2'b10});
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_drop", obsOf(0), 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    expectPattern("async_post", 0, patB1, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("async_post_idle", obsOf(0), 3'b000);

    // LEN=1: a single cycle with last high throughout.
    resetDut("rst_len1");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("len1_emit", obsOf(3), 3'b111);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("len1_idle", obsOf(3), 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
